// File: rtl/scaler_pkg.sv
// Shared types for the image-scaling engine: op encoding, FSM states
// and accumulator sizing used by the block-average unit.
package scaler_pkg;

    typedef enum logic [1:0] {
        OP_COPY = 2'd0,
        OP_UP   = 2'd1,
        OP_DEC  = 2'd2,
        OP_AVG  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int PIX_W_DEF    = 8;
    localparam int MAX_LOG2_DEF = 2;

    // A block of F*F pixels needs 2*log2(F) extra bits of headroom.
    localparam int ACC_W = PIX_W_DEF + 2 * MAX_LOG2_DEF;

    function automatic int acc_w(input int pix_w, input int max_log2);
        return pix_w + 2 * max_log2;
    endfunction

endpackage

// File: rtl/scaler_block_accum.sv
// Block-average unit: clears on the first pixel of a block, accumulates
// the rest, and presents floor(sum / F^2) combinationally.
// Ports: clk, reset (async, active-low), vld_i (pixel valid),
//   clr_i (first pixel of block), k_i (log2 F), pix_i (pixel in),
//   avg_o (average including the current pixel).
module scaler_block_accum
    import scaler_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int MAX_LOG2 = MAX_LOG2_DEF,
    parameter int ACC_W    = acc_w(PIX_W, MAX_LOG2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vld_i,
    input  logic             clr_i,
    input  logic [1:0]       k_i,
    input  logic [PIX_W-1:0] pix_i,
    output logic [PIX_W-1:0] avg_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;

    always_comb begin
        sum   = (clr_i ? '0 : acc_q) + ACC_W'(pix_i);
        acc_d = vld_i ? sum : acc_q;
        // Divide by F^2 = shift by 2k; the result always fits in PIX_W.
        avg_o = PIX_W'(sum >> {k_i, 1'b0});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/img_scaler_engine.sv
// Image-scaling engine: streams ROM pixels, writes scaled pixels to RAM.
// Ops COPY/UP/DEC/AVG at factor 1<<k; start/busy/done handshake.
// Ports: clk, reset (async, active-low), start, op, fact_log2, abort,
//   busy, done, err, rom_addr, rom_data, ram_wraddr, ram_data, ram_wren.
// Build option: SCALER_AVG_EN compiles in the block-average datapath.
module img_scaler_engine
    import scaler_pkg::*;
#(
    parameter int SRC_W    = 160,
    parameter int SRC_H    = 120,
    parameter int DST_W    = 640,
    parameter int PIX_W    = 8,
    parameter int ADDR_W   = 19,
    parameter int MAX_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [1:0]        fact_log2,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [PIX_W-1:0]  ram_data,
    output logic              ram_wren
);

    localparam logic [ADDR_W-1:0] SW  = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] SH  = ADDR_W'(SRC_H);
    localparam logic [ADDR_W-1:0] DW  = ADDR_W'(DST_W);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_e state_q, state_d;
    op_e    op_q, op_d, op_in;
    logic [1:0] k_q, k_d;
    logic       err_q, err_d;

    // Output-pixel coordinates and sub-block / replication counters.
    logic [ADDR_W-1:0] ox_q, ox_d, oy_q, oy_d;
    logic [ADDR_W-1:0] bx_q, bx_d, by_q, by_d;

    // Source pointers: read row, read column, block column, block row.
    logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] cx_q, cx_d, base_q, base_d;

    // Destination pointers for the pixel being read.
    logic [ADDR_W-1:0] dst_row_q, dst_row_d, dst_q, dst_d;

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    // Stage tracking the read whose data arrives this cycle.
    logic              p1_vld_q, p1_vld_d;
    logic              p1_last_q, p1_last_d;
    logic [ADDR_W-1:0] p1_dst_q, p1_dst_d;

    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              wren_q, wren_d;

    logic [ADDR_W-1:0] f, fm1, sw_k, xlast, ylast;
    logic [ADDR_W-1:0] nb_cx, nb_base;
    logic              is_avg, pix_done, row_adv, fin, k_bad, bad_req;
    logic [PIX_W-1:0]  pix_out;

    assign op_in = op_e'(op);
    assign k_bad = int'(fact_log2) > MAX_LOG2;

`ifdef SCALER_AVG_EN
    assign bad_req = k_bad;
    assign is_avg  = (op_q == OP_AVG);
`else
    assign bad_req = k_bad || (op_in == OP_AVG);
    assign is_avg  = 1'b0;
`endif

    assign f    = ONE << k_q;
    assign fm1  = f - ONE;
    assign sw_k = SW << k_q;

    assign xlast = (op_q == OP_UP) ? (SW << k_q) - ONE
                                   : (SW >> k_q) - ONE;
    assign ylast = (op_q == OP_UP) ? (SH << k_q) - ONE
                                   : (SH >> k_q) - ONE;

    // Non-average ops finish a pixel on every read.
    assign pix_done = !is_avg || ((bx_q == fm1) && (by_q == fm1));
    assign row_adv  = (ox_q == xlast);
    assign fin      = row_adv && (oy_q == ylast) && pix_done;

    // Next block origin for DEC/COPY and for AVG at block end.
    assign nb_cx   = row_adv ? '0 : cx_q + f;
    assign nb_base = row_adv ? base_q + sw_k : base_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        k_d       = k_q;
        err_d     = err_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        bx_d      = bx_q;
        by_d      = by_q;
        row_d     = row_q;
        col_d     = col_q;
        cx_d      = cx_q;
        base_d    = base_q;
        dst_row_d = dst_row_q;
        dst_d     = dst_q;
        p1_vld_d  = 1'b0;
        p1_last_d = p1_last_q;
        p1_dst_d  = p1_dst_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = bad_req;
                    state_d = bad_req ? S_DONE : S_RUN;
                    // k=0 degenerates to COPY; COPY ignores k.
                    op_d    = (fact_log2 == 2'd0) ? OP_COPY : op_in;
                    k_d     = (op_in == OP_COPY) ? 2'd0 : fact_log2;
                    ox_d      = '0;
                    oy_d      = '0;
                    bx_d      = '0;
                    by_d      = '0;
                    row_d     = '0;
                    col_d     = '0;
                    cx_d      = '0;
                    base_d    = '0;
                    dst_row_d = '0;
                    dst_d     = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    p1_vld_d  = 1'b1;
                    p1_last_d = pix_done;
                    p1_dst_d  = dst_q;
                    if (fin) begin
                        state_d = S_DRAIN;
                    end else begin
                        if (pix_done) begin
                            if (row_adv) begin
                                ox_d      = '0;
                                oy_d      = oy_q + ONE;
                                dst_row_d = dst_row_q + DW;
                                dst_d     = dst_row_q + DW;
                            end else begin
                                ox_d  = ox_q + ONE;
                                dst_d = dst_q + ONE;
                            end
                        end
                        unique case (op_q)
                            OP_UP: begin
                                // bx/by count output repeats of one source pixel.
                                if (row_adv) begin
                                    col_d = '0;
                                    bx_d  = '0;
                                    if (by_q == fm1) begin
                                        by_d  = '0;
                                        row_d = row_q + SW;
                                    end else begin
                                        by_d = by_q + ONE;
                                    end
                                end else if (bx_q == fm1) begin
                                    bx_d  = '0;
                                    col_d = col_q + ONE;
                                end else begin
                                    bx_d = bx_q + ONE;
                                end
                            end
`ifdef SCALER_AVG_EN
                            OP_AVG: begin
                                // Raster walk inside the F x F block.
                                if (bx_q != fm1) begin
                                    bx_d  = bx_q + ONE;
                                    col_d = col_q + ONE;
                                end else if (by_q != fm1) begin
                                    bx_d  = '0;
                                    by_d  = by_q + ONE;
                                    row_d = row_q + SW;
                                    col_d = cx_q;
                                end else begin
                                    bx_d   = '0;
                                    by_d   = '0;
                                    cx_d   = nb_cx;
                                    col_d  = nb_cx;
                                    base_d = nb_base;
                                    row_d  = nb_base;
                                end
                            end
`endif
                            default: begin
                                cx_d   = nb_cx;
                                col_d  = nb_cx;
                                base_d = nb_base;
                                row_d  = nb_base;
                            end
                        endcase
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!p1_vld_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase

        rom_addr_d = row_d + col_d;

        // p1 is only valid in RUN/DRAIN, so abort alone kills the write.
        wren_d    = p1_vld_q && p1_last_q && !abort;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (p1_vld_q && p1_last_q) begin
            wr_addr_d = p1_dst_q;
            wr_data_d = pix_out;
        end
    end

`ifdef SCALER_AVG_EN
    localparam int AW = acc_w(PIX_W, MAX_LOG2);

    logic             p1_first_q;
    logic [PIX_W-1:0] avg_pix;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_first_q <= 1'b0;
        end else begin
            p1_first_q <= (bx_q == '0) && (by_q == '0);
        end
    end

    scaler_block_accum #(
        .PIX_W    (PIX_W),
        .MAX_LOG2 (MAX_LOG2),
        .ACC_W    (AW)
    ) u_accum (
        .clk   (clk),
        .reset (reset),
        .vld_i (p1_vld_q && is_avg),
        .clr_i (p1_first_q),
        .k_i   (k_q),
        .pix_i (rom_data),
        .avg_o (avg_pix)
    );

    assign pix_out = is_avg ? avg_pix : rom_data;
`else
    assign pix_out = rom_data;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_COPY;
            k_q        <= '0;
            err_q      <= 1'b0;
            ox_q       <= '0;
            oy_q       <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            cx_q       <= '0;
            base_q     <= '0;
            dst_row_q  <= '0;
            dst_q      <= '0;
            rom_addr_q <= '0;
            p1_vld_q   <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_dst_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wren_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            k_q        <= k_d;
            err_q      <= err_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cx_q       <= cx_d;
            base_q     <= base_d;
            dst_row_q  <= dst_row_d;
            dst_q      <= dst_d;
            rom_addr_q <= rom_addr_d;
            p1_vld_q   <= p1_vld_d;
            p1_last_q  <= p1_last_d;
            p1_dst_q   <= p1_dst_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wren_q     <= wren_d;
        end
    end

    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign rom_addr   = rom_addr_q;
    assign ram_wraddr = wr_addr_q;
    assign ram_data   = wr_data_q;
    assign ram_wren   = wren_q;

endmodule

// File: tb/tb_img_scaler_engine.sv
// Directed bench for img_scaler_engine on an 8x4 source, 32-pixel stride.
// Ports: none (top-level bench).
module tb_img_scaler_engine;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [1:0] fact_log2;
    logic       abort;
    logic       busy;
    logic       done;
    logic       err;
    logic [9:0] rom_addr;
    logic [7:0] rom_data;
    logic [9:0] ram_wraddr;
    logic [7:0] ram_data;
    logic       ram_wren;

    logic [7:0] rom_mem [32];
    logic [7:0] ram_mem [1024];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    int off;
    int wr_cnt = 0;
    int done_cnt = 0;
    int both_cnt = 0;
    int first_wr = -1;

    img_scaler_engine #(
        .SRC_W    (8),
        .SRC_H    (4),
        .DST_W    (32),
        .PIX_W    (8),
        .ADDR_W   (10),
        .MAX_LOG2 (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .fact_log2  (fact_log2),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ram_wraddr (ram_wraddr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) rom_data <= rom_mem[rom_addr[4:0]];

    always @(negedge clk) begin
        if (ram_wren === 1'b1) begin
            ram_mem[ram_wraddr] = ram_data;
            wr_cnt = wr_cnt + 1;
            if (first_wr < 0) first_wr = cyc;
        end
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (ram_wren === 1'b1 && done === 1'b1) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 1024; i++) ram_mem[i] = 8'hEE;
        wr_cnt   = 0;
        done_cnt = 0;
        both_cnt = 0;
        first_wr = -1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [1:0] k);
        @(negedge clk);
        op        = o;
        fact_log2 = k;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(input int budget, output int o);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        o = (done === 1'b1) ? cyc - t0 : -1;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        op        = 2'd0;
        fact_log2 = 2'd0;
        abort     = 1'b0;
        for (int i = 0; i < 32; i++) rom_mem[i] = 8'(i);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_wraddr", ram_wraddr, 0);
        chk("rst_data", ram_data, 0);
        chk("rst_wren", ram_wren, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // COPY k=0
        clear_obs();
        launch(2'd0, 2'd0);
        chk("copy_busy", busy, 1);
        chk("copy_addr0", rom_addr, 0);
        wait_done(200, off);
        chk("copy_done_at", off, 34);
        chk("copy_busy_fall", busy, 0);
        @(negedge clk);
        chk("copy_done_pulse", done, 0);
        chk("copy_writes", wr_cnt, 32);
        chk("copy_first_wr", first_wr - t0, 2);
        chk("copy_px00", ram_mem[0], 0);
        chk("copy_px21", ram_mem[1*32+2], 10);
        chk("copy_px73", ram_mem[3*32+7], 31);
        chk("copy_done_cnt", done_cnt, 1);

        // UP k=2, plus a start pulse while busy
        clear_obs();
        launch(2'd1, 2'd2);
        repeat (10) @(negedge clk);
        op        = 2'd0;
        fact_log2 = 2'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1000, off);
        chk("up_done_at", off, 514);
        @(negedge clk);
        chk("up_writes", wr_cnt, 512);
        chk("up_px95", ram_mem[5*32+9], 10);
        chk("up_px00", ram_mem[0], 0);
        chk("up_px_last", ram_mem[15*32+31], 31);
        chk("up_done_cnt", done_cnt, 1);

        // DEC k=2
        clear_obs();
        launch(2'd2, 2'd2);
        @(negedge clk);
        chk("dec_addr1", rom_addr, 4);
        wait_done(100, off);
        chk("dec_done_at", off, 4);
        @(negedge clk);
        chk("dec_writes", wr_cnt, 2);
        chk("dec_px0", ram_mem[0], 0);
        chk("dec_px1", ram_mem[1], 4);

        // Illegal k=3
        clear_obs();
        launch(2'd2, 2'd3);
        chk("badk_busy", busy, 0);
        wait_done(10, off);
        chk("badk_done_at", off, 0);
        chk("badk_err", err, 1);
        @(negedge clk);
        chk("badk_done_pulse", done, 0);
        repeat (3) @(negedge clk);
        chk("badk_err_sticky", err, 1);
        chk("badk_writes", wr_cnt, 0);

`ifdef SCALER_AVG_EN
        rom_mem[0]  = 8'd1;
        rom_mem[1]  = 8'd2;
        rom_mem[8]  = 8'd3;
        rom_mem[9]  = 8'd5;
        rom_mem[2]  = 8'd255;
        rom_mem[3]  = 8'd255;
        rom_mem[10] = 8'd255;
        rom_mem[11] = 8'd255;
        clear_obs();
        launch(2'd3, 2'd1);
        wait_done(200, off);
        chk("avg_done_at", off, 34);
        @(negedge clk);
        chk("avg_writes", wr_cnt, 8);
        chk("avg_first_wr", first_wr - t0, 5);
        chk("avg_px0", ram_mem[0], 2);
        chk("avg_px1", ram_mem[1], 255);
        chk("avg_px2", ram_mem[2], 8);
        chk("avg_px13", ram_mem[32+3], 26);
        chk("avg_err", err, 0);
        for (int i = 0; i < 32; i++) rom_mem[i] = 8'(i);
`else
        clear_obs();
        launch(2'd3, 2'd1);
        wait_done(10, off);
        chk("avg_off_done_at", off, 0);
        chk("avg_off_err", err, 1);
        @(negedge clk);
        chk("avg_off_writes", wr_cnt, 0);
`endif

        // Abort after 5 writes, then a clean COPY
        clear_obs();
        launch(2'd0, 2'd0);
        chk("abort_err_clr", err, 0);
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_wren", ram_wren, 0);
        repeat (5) @(negedge clk);
        chk("abort_writes", wr_cnt, 5);
        chk("abort_no_done", done_cnt, 0);
        clear_obs();
        launch(2'd0, 2'd0);
        wait_done(200, off);
        chk("reabort_done_at", off, 34);
        @(negedge clk);
        chk("reabort_writes", wr_cnt, 32);
        chk("reabort_px73", ram_mem[3*32+7], 31);

        // Reset in the middle of UP, then rerun
        clear_obs();
        launch(2'd1, 2'd2);
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wren", ram_wren, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        chk("mid_rst_wraddr", ram_wraddr, 0);
        chk("mid_rst_data", ram_data, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_obs();
        launch(2'd1, 2'd2);
        wait_done(1000, off);
        chk("rerun_done_at", off, 514);
        @(negedge clk);
        chk("rerun_writes", wr_cnt, 512);
        chk("rerun_px95", ram_mem[5*32+9], 10);
        chk("rerun_px_last", ram_mem[15*32+31], 31);
        chk("rerun_done_cnt", done_cnt, 1);
        chk("wren_with_done", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
